// File: rtl/alu_pkg.sv
// Shared types and op-class decode for the multicycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd   = 4'h0,
    OpOr    = 4'h1,
    OpAdd   = 4'h2,
    OpSlt   = 4'h3,
    OpXor   = 4'h4,
    OpNor   = 4'h5,
    OpSub   = 4'h6,
    OpSltu  = 4'h7,
    OpMultu = 4'h8,
    OpMult  = 4'h9,
    OpDivu  = 4'ha,
    OpDiv   = 4'hb,
    OpMfhi  = 4'hc,
    OpMflo  = 4'hd
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFin
  } state_t;

  // op[3:2] == 2'b10 selects MULTU/MULT/DIVU/DIV; op[1] = divide, op[0] = signed
  localparam logic [1:0] MulDivClass = 2'b10;

  function automatic logic op_is_muldiv(alu_op_t op);
    return op[3:2] == MulDivClass;
  endfunction

  function automatic logic op_is_div(alu_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(alu_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up applied combinationally to the final HI/LO pair.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             step_done,
  output logic [WIDTH-1:0] q_or_lo,
  output logic [WIDTH-1:0] r_or_hi
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [CntW-1:0]  cnt_q;
  logic             div_q, neg_q, neg_rem_q, hold_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    mag_a    = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b    = (is_signed && b[WIDTH-1]) ? -b : b;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hold_q    <= 1'b0;
    end else if (load) begin
      div_q <= is_div;
      m_q   <= mag_b;
      if (is_div && (b == '0)) begin
        // Divide by zero: one idle count, results preloaded, no sign fix-up.
        cnt_q     <= CntW'(1);
        hi_q      <= a;
        lo_q      <= '1;
        neg_q     <= 1'b0;
        neg_rem_q <= 1'b0;
        hold_q    <= 1'b1;
      end else begin
        cnt_q     <= CntW'(WIDTH);
        hi_q      <= '0;
        lo_q      <= mag_a;
        neg_q     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_q <= is_signed & is_div & a[WIDTH-1];
        hold_q    <= 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
      if (!hold_q) begin
        if (div_q) begin
          if (!div_diff[WIDTH]) begin
            hi_q <= div_diff[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= div_sh[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
        end
      end
    end
  end

  assign step_done = (cnt_q == CntW'(1));

  always_comb begin
    if (div_q) begin
      q_or_lo = neg_q ? -lo_q : lo_q;
      r_or_hi = neg_rem_q ? -hi_q : hi_q;
    end else begin
      {r_or_hi, q_or_lo} = prod_fix;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multicycle ALU: single-cycle logic/arith/compare plus iterative mul/div into HI/LO,
// behind a start/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, hi_q, hi_d, lo_q, lo_d, alu_res;
  logic             zero_q, zero_d, done_q, done_d, dbz_q, dbz_d, pend_q, pend_d;
  logic             md_load, md_step_done, slt, sltu;
  logic [WIDTH-1:0] md_q_or_lo, md_r_or_hi;

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (md_load),
    .is_div   (op_is_div(op)),
    .is_signed(op_is_signed(op)),
    .a        (a),
    .b        (b),
    .step_done(md_step_done),
    .q_or_lo  (md_q_or_lo),
    .r_or_hi  (md_r_or_hi)
  );

  // Direct signed compare, immune to the overflow of a - b.
  assign slt  = $signed(a) < $signed(b);
  assign sltu = a < b;

  always_comb begin
    alu_res = '0;
    case (op)
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpAdd:   alu_res = a + b;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt};
      OpXor:   alu_res = a ^ b;
      OpNor:   alu_res = ~(a | b);
      OpSub:   alu_res = a - b;
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, sltu};
      OpMfhi:  alu_res = hi_q;
      OpMflo:  alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    pend_d  = pend_q;
    md_load = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (op_is_muldiv(op)) begin
            md_load = 1'b1;
            pend_d  = op_is_div(op) && (b == '0);
            state_d = op_is_div(op) ? StDiv : StMul;
          end else begin
            y_d    = alu_res;
            zero_d = (alu_res == '0);
            done_d = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        if (md_step_done) state_d = StFin;
      end
      StFin: begin
        hi_d    = md_r_or_hi;
        lo_d    = md_q_or_lo;
        done_d  = 1'b1;
        dbz_d   = pend_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      y_q     <= '0;
      zero_q  <= 1'b1;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      pend_q  <= pend_d;
    end
  end

  assign y           = y_q;
  assign zero        = zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q == StMul) || (state_q == StDiv);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected completions, a negedge monitor
// pops and compares on every done pulse. Latency = completing edge minus start edge.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        dbz;
    int          lat;
    int          issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  alu_op_t     op = OpAnd;
  logic [31:0] a = '0, b = '0, y, hi, lo;
  logic        zero, busy, done, dbz;

  logic        start8 = 1'b0;
  alu_op_t     op8 = OpAnd;
  logic [7:0]  a8 = '0, b8 = '0, y8, hi8, lo8;
  logic        zero8, busy8, done8, dbz8;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_y = '0, m_hi = '0, m_lo = '0;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .y(y), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(dbz)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .y(y8), .zero(zero8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      check("done_busy_exclusive", 64'(busy), 64'(0));
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_y"}, 64'(y), 64'(e.y));
        check({e.name, "_zero"}, 64'(zero), 64'(e.zero));
        check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        check({e.name, "_dbz"}, 64'(dbz), 64'(e.dbz));
        check({e.name, "_latency"}, 64'(cyc - e.issue), 64'(e.lat));
      end
    end
  end

  // Operands are scrambled after the start cycle to show they are captured.
  task automatic drive(input alu_op_t o, input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1; op = o; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; op = OpAnd; a = ~aa; b = ~bb;
  endtask

  task automatic issue_sc(input string nm, input alu_op_t o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] ey, input bit now);
    exp_t x;
    if (!now) @(negedge clk);
    x = '{name: nm, y: ey, hi: m_hi, lo: m_lo, zero: (ey == 0), dbz: 1'b0, lat: 0,
          issue: cyc + 1};
    sb.push_back(x);
    m_y = ey;
    drive(o, aa, bb);
  endtask

  task automatic issue_md(input string nm, input alu_op_t o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edbz, input int elat);
    exp_t x;
    @(negedge clk);
    x = '{name: nm, y: m_y, hi: ehi, lo: elo, zero: (m_y == 0), dbz: edbz, lat: elat,
          issue: cyc + 1};
    sb.push_back(x);
    m_hi = ehi;
    m_lo = elo;
    drive(o, aa, bb);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL completion_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic mul8(input string nm, input alu_op_t o, input logic [7:0] aa,
                      input logic [7:0] bb, input logic [7:0] ehi, input logic [7:0] elo);
    int ic;
    bit found;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = aa; b8 = bb;
    ic = cyc + 1;
    @(negedge clk);
    start8 = 1'b0; a8 = '0; b8 = '0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done8) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_done_seen"}, 64'(found), 64'(1));
    check({nm, "_latency"}, 64'(cyc - ic), 64'(9));
    check({nm, "_hi"}, 64'(hi8), 64'(ehi));
    check({nm, "_lo"}, 64'(lo8), 64'(elo));
  endtask

  initial begin
    bit got;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_y", 64'(y), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_zero", 64'(zero), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(dbz), 64'(0));

    issue_sc("slt_ovf", OpSlt, 32'h7fff_ffff, 32'h8000_0000, 32'h0, 0);   wait_idle();
    issue_sc("sltu", OpSltu, 32'h7fff_ffff, 32'h8000_0000, 32'h1, 0);     wait_idle();
    issue_sc("sub_zero", OpSub, 32'd5, 32'd5, 32'h0, 0);                  wait_idle();
    issue_sc("add_wrap", OpAdd, 32'hffff_ffff, 32'd2, 32'h1, 0);          wait_idle();
    issue_sc("and", OpAnd, 32'hf0f0_f0f0, 32'h0ff0_0ff0, 32'h00f0_00f0, 0); wait_idle();
    issue_sc("or", OpOr, 32'hf0f0_f0f0, 32'h0ff0_0ff0, 32'hfff0_fff0, 0);  wait_idle();
    issue_sc("xor", OpXor, 32'hf0f0_f0f0, 32'h0ff0_0ff0, 32'hff00_ff00, 0); wait_idle();
    issue_sc("nor", OpNor, 32'hf0f0_f0f0, 32'h0ff0_0ff0, 32'h000f_000f, 0); wait_idle();
    issue_sc("slt_neg", OpSlt, 32'hffff_ffff, 32'd1, 32'h1, 0);           wait_idle();
    issue_sc("illegal", alu_op_t'(4'he), 32'h1234, 32'h5678, 32'h0, 0);   wait_idle();

    issue_md("mult", OpMult, 32'hffff_fffd, 32'd7, 32'hffff_ffff, 32'hffff_ffeb, 0, 33);
    wait_idle();
    issue_md("multu", OpMultu, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h1, 0, 33);
    wait_idle();
    issue_md("div_neg", OpDiv, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 0, 33);
    wait_idle();
    issue_md("div_min", OpDiv, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 0, 33);
    wait_idle();
    issue_sc("mflo", OpMflo, 32'h0, 32'h0, 32'h8000_0000, 0);             wait_idle();
    issue_sc("mfhi", OpMfhi, 32'h0, 32'h0, 32'h0, 0);                     wait_idle();
    issue_md("divu_zero", OpDivu, 32'd9, 32'd0, 32'd9, 32'hffff_ffff, 1, 2);
    wait_idle();
    issue_md("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 0, 33);
    wait_idle();

    // A start during busy must be dropped; a stray completion trips the monitor.
    issue_md("multu_busy", OpMultu, 32'd6, 32'd7, 32'h0, 32'd42, 0, 33);
    repeat (3) @(negedge clk);
    check("busy_during_mul", 64'(busy), 64'(1));
    start = 1'b1; op = OpAdd; a = 32'd100; b = 32'd200;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    issue_sc("mflo_after_busy", OpMflo, 32'h0, 32'h0, 32'd42, 0);        wait_idle();

    // Back-to-back: next start driven while done is high.
    issue_md("mult_b2b", OpMult, 32'd5, 32'hffff_fffc, 32'hffff_ffff, 32'hffff_ffec, 0, 33);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("b2b_done_seen", 64'(got), 64'(1));
    issue_sc("add_b2b", OpAdd, 32'd1, 32'd2, 32'd3, 1);
    wait_idle();

    // Asynchronous reset in the middle of a multiply.
    issue_md("mult_abort", OpMultu, 32'd3, 32'd3, 32'h0, 32'd9, 0, 33);
    repeat (4) @(negedge clk);
    check("busy_before_abort", 64'(busy), 64'(1));
    sb.delete();
    #3 reset_n = 1'b0;
    #1;
    check("abort_y", 64'(y), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_zero", 64'(zero), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("abort_done", 64'(done), 64'(0));
    reset_n = 1'b1;
    m_y = '0; m_hi = '0; m_lo = '0;
    repeat (40) @(negedge clk);
    check("abort_no_late_done_lo", 64'(lo), 64'(0));

    mul8("mult8", OpMult, 8'hfd, 8'h07, 8'hff, 8'heb);
    mul8("multu8", OpMultu, 8'd200, 8'd3, 8'h02, 8'h58);

    wait_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle datapath ALU for the multicycle MIPS core. It keeps the single-cycle logic/arithmetic/compare operations, registers them behind a start/done handshake, adds XOR, NOR, SLTU and overflow-correct signed SLT, and adds iterative signed/unsigned multiply and divide into internal HI/LO registers (MULT/MULTU/DIV/DIVU, MFHI/MFLO). The core's control FSM issues one operation per start pulse and stalls on busy.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  issue request; sampled only when busy = 0.
- op  in  4  operation code, alu_pkg::alu_op_t; sampled with start.
- a, b  in  WIDTH  operands; sampled with start.
- y  out  WIDTH  registered result; holds until the next completion.
- zero  out  1  registered, (y == 0).
- hi, lo  out  WIDTH  HI/LO registers.
- busy  out  1  multiply/divide in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  valid with done; set only for DIV/DIVU with b == 0.

## Operation
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLT (signed), 0100 XOR, 0101 NOR, 0110 SUB, 0111 SLTU.
  - 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV, 1100 MFHI, 1101 MFLO.
  - 1110/1111 illegal: y = 0, done still pulses.
- ADD/SUB wrap modulo 2^WIDTH; no overflow output.
- SLT is the true signed comparison (overflow-safe, not the sign of the difference); SLT/SLTU give y = {WIDTH-1 zeros, cmp}.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE + start + single-cycle op: load y, pulse done, stay in IDLE.
  - IDLE + start + MULT/MULTU: capture operand magnitudes and signs, counter = WIDTH → MUL.
  - IDLE + start + DIV/DIVU with b ≠ 0: same capture → DIV.
  - MUL/DIV: one shift-add or restoring-subtract step per cycle; counter decrements; at counter 1 → FIN.
  - FIN: apply signs, write hi/lo, pulse done → IDLE.
- Signed results:
  - MULT: {hi,lo} = signed 2·WIDTH product.
  - DIV: quotient (lo) truncates toward zero; remainder (hi) takes the sign of a.
  - MIN / −1 gives lo = MIN, hi = 0.
- DIV/DIVU with b == 0: no iteration; FIN next cycle; hi = a, lo = all ones, div_by_zero = 1.
- Multiply/divide ops leave y unchanged.
- start while busy = 1 is ignored; no queueing.
- op, a and b may change after the start cycle.

## Timing
- Reset (async, reset_n = 0): y, hi, lo = 0; zero = 1; busy, done, div_by_zero = 0; state IDLE.
- Reset asserted mid-operation aborts the operation; no partial hi/lo write.
- Single-cycle ops: start sampled at edge E; y, zero and done are valid after E (latency 1).
- MUL/DIV: busy = 1 after E through edge E+WIDTH; FIN occupies the cycle after E+WIDTH; hi/lo and done update at E+WIDTH+1 (latency WIDTH+1).
- Divide by zero: done at E+2.
- done and busy are never both 1.
- A new start is accepted in the same cycle that done is high.

## Structure
- alu_pkg holds:
  - alu_op_t (4-bit enum, codes above);
  - state_t {IDLE, MUL, DIV, FIN};
  - localparams for op-class decode (is_muldiv).
- Sub-module muldiv_iter #(WIDTH):
  - owns the magnitude accumulator, shift registers, counter and sign fix-up;
  - interface: load, is_div, is_signed, a, b, step_done, q_or_lo, r_or_hi.
- alu_seq holds the combinational single-cycle datapath, FSM, y/hi/lo registers and flags.

## Test plan
- Reset: assert reset_n = 0 mid-MULT → y = hi = lo = 0, zero = 1, busy = 0 immediately (no clock needed).
- WIDTH = 32, SLT a = 0x7FFFFFFF, b = 0x80000000 → y = 0; SLTU same operands → y = 1; SUB 5−5 → y = 0, zero = 1, done one cycle after start.
- MULT a = −3, b = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, done exactly 33 cycles after start; MULTU 0xFFFFFFFF² → hi = 0xFFFFFFFE, lo = 1.
- DIV a = −7, b = 2 → lo = −3, hi = −1; DIV 0x80000000 / −1 → lo = 0x80000000, hi = 0; MFLO then returns y = lo.
- DIVU a = 9, b = 0 → hi = 9, lo = 0xFFFFFFFF, div_by_zero = 1, done 2 cycles after start.
- start pulsed during busy (ADD) → ignored, y unchanged; back-to-back start on the done cycle → accepted; repeat MULT with WIDTH = 8 → latency 9.
